team_08_tft_ili9341_rx: RTL

- Display-side receiver for the ILI9341 4-wire SPI stream (sck/sdi/dc/cs) that our TFT driver emits; the other end of that link.
- Oversamples the bus on the system clock, assembles bytes, and decodes SWRESET/SLPOUT/DISPON/CASET/PASET/RAMWR.
- Turns RAMWR pixel data into framebuffer write strobes.
- Used as an in-fabric display emulator for bench and FPGA loopback, so driver output can be checked without a panel.

---
 rtl/team_08_tft_ili9341_rx_pkg.sv | 24 ++
 rtl/team_08_tft_ili9341_rx_if.sv | 12 +
 rtl/team_08_tft_spi_rx_byte.sv | 91 +++++++++
 rtl/team_08_tft_ili9341_rx.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/team_08_tft_ili9341_rx_pkg.sv
// Shared opcodes, decoder states and panel geometry for the ILI9341 stream receiver.
// Constant data only: no latency or backpressure of its own.
package team_08_tft_pkg;

    localparam int DEF_WIDTH  = 240;
    localparam int DEF_HEIGHT = 320;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_SKIP
    } dec_state_e;

endpackage

// File: rtl/team_08_tft_ili9341_rx_if.sv
// Framebuffer write port of the display emulator: strobe, address and RGB565 pixel.
// Fire-and-forget strobe, the sink cannot stall it.
interface team_08_tft_ili9341_rx_if #(
    parameter int ADDR_W = 17
) ();
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_wdata;

    modport master (output fb_we, output fb_addr, output fb_wdata);
    modport slave  (input  fb_we, input  fb_addr, input  fb_wdata);
endinterface

// File: rtl/team_08_tft_spi_rx_byte.sv
// Synchronises the 4-wire SPI pins, detects sck rises and assembles mode-0 bytes MSB first.
// byte_rdy 3 clk after the sck edge of the last bit; no backpressure, the bus is free-running.
module team_08_tft_spi_rx_byte (
    input  logic       clk,
    input  logic       rst,
    input  logic       tft_sck,
    input  logic       tft_sdi,
    input  logic       tft_dc,
    input  logic       tft_cs,
    output logic [7:0] byte_dat,
    output logic       is_data,
    output logic       byte_rdy,
    output logic       byte_abort
);
    // Pins packed as {sck, sdi, dc, cs}; cs idles high so reset does not fake a deselect edge.
    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic       sck_hist_q, sck_hist_d, cs_hist_q, cs_hist_d;
    logic [6:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       is_data_q, is_data_d, byte_rdy_q, byte_rdy_d, abort_q, abort_d;
    logic       sck_s, sdi_s, dc_s, cs_s, sck_rise, cs_idle, cs_rise;

    always_comb begin
        sync1_d    = {tft_sck, tft_sdi, tft_dc, tft_cs};
        sync2_d    = sync1_q;
        {sck_s, sdi_s, dc_s, cs_s} = sync2_q;
        sck_hist_d = sck_s;
        cs_hist_d  = cs_s;
        sck_rise   = sck_s & ~sck_hist_q;
        cs_idle    = cs_s & cs_hist_q;
        cs_rise    = cs_s & ~cs_hist_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_d     = byte_q;
        is_data_d  = is_data_q;
        byte_rdy_d = 1'b0;
        abort_d    = 1'b0;
        if (cs_idle) begin
            bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
            // A final bit landing together with the deselect edge still completes the byte.
            shreg_d = {shreg_q[5:0], sdi_s};
            if (bit_cnt_q == 3'd7) begin
                byte_d     = {shreg_q, sdi_s};
                is_data_d  = dc_s;
                byte_rdy_d = 1'b1;
                bit_cnt_d  = 3'd0;
            end else if (cs_rise) begin
                abort_d   = 1'b1;
                bit_cnt_d = 3'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end else if (cs_rise) begin
            abort_d   = (bit_cnt_q != 3'd0);
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 4'b0001;
            sync2_q    <= 4'b0001;
            sck_hist_q <= 1'b0;
            cs_hist_q  <= 1'b1;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            byte_q     <= '0;
            is_data_q  <= 1'b0;
            byte_rdy_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sck_hist_q <= sck_hist_d;
            cs_hist_q  <= cs_hist_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_q     <= byte_d;
            is_data_q  <= is_data_d;
            byte_rdy_q <= byte_rdy_d;
            abort_q    <= abort_d;
        end
    end

    assign byte_dat   = byte_q;
    assign is_data    = is_data_q;
    assign byte_rdy   = byte_rdy_q;
    assign byte_abort = abort_q;
endmodule

// File: rtl/team_08_tft_ili9341_rx.sv
// ILI9341 panel emulator: decodes the command/data byte stream into flags and framebuffer writes.
// fb_we / cmd_valid 4 clk after the sck edge of the last bit; no backpressure on the write port.
module team_08_tft_ili9341_rx
    import team_08_tft_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = 17
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tft_sck,
    input  logic                           tft_sdi,
    input  logic                           tft_dc,
    input  logic                           tft_cs,
    team_08_tft_ili9341_rx_if.master       fb,
    output logic                           cmd_valid,
    output logic [7:0]                     cmd_byte,
    output logic                           awake,
    output logic                           display_on,
    output logic                           byte_abort
);
    logic [7:0] byte_dat;
    logic       is_data, byte_rdy;

    team_08_tft_spi_rx_byte u_rx (
        .clk, .rst, .tft_sck, .tft_sdi, .tft_dc, .tft_cs,
        .byte_dat, .is_data, .byte_rdy, .byte_abort
    );

    dec_state_e        state_q, state_d;
    logic [1:0]        pidx_q, pidx_d;
    logic [7:0]        p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, hi_byte_q, hi_byte_d;
    logic [15:0]       sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d, col_q, col_d, row_q, row_d;
    logic              hi_pend_q, hi_pend_d, fb_we_q, fb_we_d, cmd_valid_q, cmd_valid_d;
    logic              awake_q, awake_d, disp_q, disp_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d, pix_addr;
    logic [15:0]       fb_wdata_q, fb_wdata_d, win_start, win_end_raw, win_end;
    logic [7:0]        cmd_byte_q, cmd_byte_d;
    logic              in_range;

    always_comb begin
        state_d = state_q;   pidx_d = pidx_q;   p0_d = p0_q;   p1_d = p1_q;   p2_d = p2_q;
        sc_d = sc_q;   ec_d = ec_q;   sp_d = sp_q;   ep_d = ep_q;   col_d = col_q;   row_d = row_q;
        hi_pend_d = hi_pend_q;   hi_byte_d = hi_byte_q;   fb_addr_d = fb_addr_q;   fb_wdata_d = fb_wdata_q;
        cmd_byte_d = cmd_byte_q;   awake_d = awake_q;   disp_d = disp_q;
        fb_we_d = 1'b0;   cmd_valid_d = 1'b0;
        win_start   = {p0_q, p1_q};
        win_end_raw = {p2_q, byte_dat};
        win_end     = (win_end_raw < win_start) ? win_start : win_end_raw;
        pix_addr    = ADDR_W'(32'(row_q) * 32'(WIDTH) + 32'(col_q));
        in_range    = (col_q < 16'(WIDTH)) && (row_q < 16'(HEIGHT));
        if (byte_rdy && !is_data) begin
            // Any command drops a half-received pixel and re-dispatches from scratch.
            cmd_valid_d = 1'b1;
            cmd_byte_d  = byte_dat;
            hi_pend_d   = 1'b1;
            pidx_d      = 2'd0;
            state_d     = ST_CMD;
            case (byte_dat)
                CMD_SWRESET: begin
                    awake_d = 1'b0;  disp_d = 1'b0;
                    sc_d = '0;  ec_d = 16'(WIDTH - 1);  sp_d = '0;  ep_d = 16'(HEIGHT - 1);
                end
                CMD_SLPOUT:  awake_d = 1'b1;
                CMD_DISPON:  disp_d  = 1'b1;
                CMD_DISPOFF: disp_d  = 1'b0;
                CMD_CASET:   state_d = ST_CASET;
                CMD_PASET:   state_d = ST_PASET;
                CMD_RAMWR: begin
                    state_d = ST_RAMWR;  col_d = sc_q;  row_d = sp_q;
                end
                default:     state_d = ST_SKIP;
            endcase
        end else if (byte_rdy) begin
            case (state_q)
                ST_CASET, ST_PASET: begin
                    pidx_d = pidx_q + 2'd1;
                    case (pidx_q)
                        2'd0:    p0_d = byte_dat;
                        2'd1:    p1_d = byte_dat;
                        2'd2:    p2_d = byte_dat;
                        default: begin
                            if (state_q == ST_CASET) begin
                                sc_d = win_start;  ec_d = win_end;
                            end else begin
                                sp_d = win_start;  ep_d = win_end;
                            end
                            state_d = ST_SKIP;
                        end
                    endcase
                end
                ST_RAMWR: begin
                    if (hi_pend_q) begin
                        hi_byte_d = byte_dat;
                        hi_pend_d = 1'b0;
                    end else begin
                        hi_pend_d = 1'b1;
                        if (in_range) begin
                            fb_we_d    = 1'b1;
                            fb_addr_d  = pix_addr;
                            fb_wdata_d = {hi_byte_q, byte_dat};
                        end
                        // Off-panel pixels still move the cursor so the window geometry holds.
                        if (col_q == ec_q) begin
                            col_d = sc_q;
                            row_d = (row_q == ep_q) ? sp_q : row_q + 16'd1;
                        end else begin
                            col_d = col_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CMD;  pidx_q <= '0;  p0_q <= '0;  p1_q <= '0;  p2_q <= '0;
            sc_q <= '0;  ec_q <= 16'(WIDTH - 1);  sp_q <= '0;  ep_q <= 16'(HEIGHT - 1);
            col_q <= '0;  row_q <= '0;  hi_pend_q <= 1'b1;  hi_byte_q <= '0;
            fb_we_q <= 1'b0;  fb_addr_q <= '0;  fb_wdata_q <= '0;
            cmd_valid_q <= 1'b0;  cmd_byte_q <= '0;  awake_q <= 1'b0;  disp_q <= 1'b0;
        end else begin
            state_q <= state_d;  pidx_q <= pidx_d;  p0_q <= p0_d;  p1_q <= p1_d;  p2_q <= p2_d;
            sc_q <= sc_d;  ec_q <= ec_d;  sp_q <= sp_d;  ep_q <= ep_d;
            col_q <= col_d;  row_q <= row_d;  hi_pend_q <= hi_pend_d;  hi_byte_q <= hi_byte_d;
            fb_we_q <= fb_we_d;  fb_addr_q <= fb_addr_d;  fb_wdata_q <= fb_wdata_d;
            cmd_valid_q <= cmd_valid_d;  cmd_byte_q <= cmd_byte_d;  awake_q <= awake_d;  disp_q <= disp_d;
        end
    end

    assign fb.fb_we    = fb_we_q;
    assign fb.fb_addr  = fb_addr_q;
    assign fb.fb_wdata = fb_wdata_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_byte    = cmd_byte_q;
    assign awake       = awake_q;
    assign display_on  = disp_q;
endmodule
